// File: rtl/iir.sv
// First-order IIR de-emphasis stage: pops one sample from the upstream FIFO,
// filters it, and pushes one result to the downstream FIFO.
module iir #(
  parameter int DATA_SIZE = 32,
  parameter int BITS      = 10,
  parameter int X_COEFF0  = 178,
  parameter int X_COEFF1  = 178,
  parameter int Y_COEFF1  = -666
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] x_in,
  input  logic                        x_empty,
  output logic                        x_rd_en,
  output logic signed [DATA_SIZE-1:0] y_out,
  input  logic                        y_out_full,
  output logic                        y_wr_en
);

  localparam int PW = 2 * DATA_SIZE;

  localparam logic signed [PW-1:0] C_X0 = PW'(X_COEFF0);
  localparam logic signed [PW-1:0] C_X1 = PW'(X_COEFF1);
  localparam logic signed [PW-1:0] C_Y1 = PW'(Y_COEFF1);

  typedef enum logic [1:0] {
    S_READ,
    S_CALC,
    S_WRITE
  } state_e;

  state_e                      state_q, state_d;
  logic signed [DATA_SIZE-1:0] x_cur_q, x_cur_d;
  logic signed [DATA_SIZE-1:0] x_hist_q, x_hist_d;
  logic signed [DATA_SIZE-1:0] y_hist_q, y_hist_d;
  logic signed [DATA_SIZE-1:0] y_reg_q, y_reg_d;

  logic signed [PW-1:0]        prod_x0, prod_x1, prod_y1;
  logic signed [DATA_SIZE-1:0] y_next;

  // Dequantize with truncation toward zero: shift the magnitude, then restore the sign.
  function automatic logic signed [DATA_SIZE-1:0] dq(input logic signed [PW-1:0] p);
    logic [PW-1:0] mag;
    logic [PW-1:0] q;
    mag = p[PW-1] ? $unsigned(-p) : $unsigned(p);
    q   = mag >> BITS;
    return DATA_SIZE'(p[PW-1] ? -q : q);
  endfunction

  assign prod_x0 = C_X0 * PW'(x_cur_q);
  assign prod_x1 = C_X1 * PW'(x_hist_q);
  assign prod_y1 = C_Y1 * PW'(y_hist_q);
  assign y_next  = dq(prod_x0) + dq(prod_x1) + dq(prod_y1);

  assign y_out = y_reg_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_READ;
      x_cur_q  <= '0;
      x_hist_q <= '0;
      y_hist_q <= '0;
      y_reg_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_cur_q  <= x_cur_d;
      x_hist_q <= x_hist_d;
      y_hist_q <= y_hist_d;
      y_reg_q  <= y_reg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_cur_d  = x_cur_q;
    x_hist_d = x_hist_q;
    y_hist_d = y_hist_q;
    y_reg_d  = y_reg_q;
    case (state_q)
      S_READ: begin
        if (!x_empty) begin
          x_cur_d = x_in;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        y_reg_d = y_next;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // History only advances once the result is actually accepted downstream.
        if (!y_out_full) begin
          x_hist_d = x_cur_q;
          y_hist_d = y_reg_q;
          state_d  = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  always_comb begin
    x_rd_en = 1'b0;
    y_wr_en = 1'b0;
    case (state_q)
      S_READ:  x_rd_en = !x_empty;
      S_WRITE: y_wr_en = !y_out_full;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iir.sv
// Directed bench for iir: table of filter vectors plus hand-written
// latency, backpressure, starvation and mid-stream reset sequences.
module tb_iir;

  localparam int W = 32;

  logic                clock = 1'b0;
  logic                reset;
  logic signed [W-1:0] x_in;
  logic                x_empty;
  logic                x_rd_en;
  logic signed [W-1:0] y_out;
  logic                y_out_full;
  logic                y_wr_en;

  int total = 0;
  int bad   = 0;

  iir dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .x_empty   (x_empty),
    .x_rd_en   (x_rd_en),
    .y_out     (y_out),
    .y_out_full(y_out_full),
    .y_wr_en   (y_wr_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit                  resetFirst;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    string               name;
  } vec_t;

  vec_t vecs[$];

  logic signed [W-1:0] mXh;
  logic signed [W-1:0] mYh;

  // Reference dequantizer: SV integer division already truncates toward zero.
  function automatic logic signed [W-1:0] refDq(input longint p);
    longint q;
    q = p / 1024;
    return W'(q);
  endfunction

  task automatic modelStep(input logic signed [W-1:0] x, output logic signed [W-1:0] y);
    y = refDq(longint'(178) * longint'(x)) + refDq(longint'(178) * longint'(mXh))
      + refDq(longint'(-666) * longint'(mYh));
    mXh = x;
    mYh = y;
  endtask

  task automatic addVec(input bit rf, input logic signed [W-1:0] x,
                        input logic signed [W-1:0] y, input string name);
    vec_t v;
    v.resetFirst = rf;
    v.x          = x;
    v.y          = y;
    v.name       = name;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic signed [W-1:0] act,
                             input logic signed [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset      = 1'b0;
    x_empty    = 1'b1;
    y_out_full = 1'b0;
    x_in       = '0;
    #1;
    checkOutput("reset_rd_en", W'(x_rd_en), 0);
    checkOutput("reset_wr_en", W'(y_wr_en), 0);
    checkOutput("reset_y_out", y_out, 0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Offers one sample and returns at the falling edge after it was popped.
  task automatic applyStimulus(input logic signed [W-1:0] x);
    bit got;
    got     = 1'b0;
    x_in    = x;
    x_empty = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (x_rd_en) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (got) begin
      @(negedge clock);
    end else begin
      timeoutFail("pop_wait");
    end
    x_empty = 1'b1;
  endtask

  task automatic waitWrite(input logic signed [W-1:0] exp, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (y_wr_en) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    if (got) begin
      checkOutput(name, y_out, exp);
      @(negedge clock);
    end else begin
      timeoutFail(name);
    end
  endtask

  initial begin
    logic signed [W-1:0] xs[5];
    logic signed [W-1:0] ym;

    reset      = 1'b0;
    x_empty    = 1'b1;
    y_out_full = 1'b0;
    x_in       = '0;

    addVec(1'b1, 1024, 178, "impulse");
    addVec(1'b0, 0, 63, "impulse");
    addVec(1'b0, 0, -40, "impulse");
    addVec(1'b1, 1024, 178, "step");
    addVec(1'b0, 1024, 241, "step");
    addVec(1'b0, 1024, 200, "step");
    addVec(1'b1, -1024, -178, "neg_impulse");
    addVec(1'b0, 0, -63, "neg_impulse");
    addVec(1'b0, 0, 40, "neg_impulse");
    addVec(1'b1, 32'sh7FFFFFFF, 373293055, "max_step_hand");
    addVec(1'b0, 32'sh7FFFFFFF, 503799807, "max_step_hand");
    addVec(1'b0, 32'sh7FFFFFFF, 418919439, "max_step_hand");

    xs[0] = 32'sh7FFFFFFF;
    xs[1] = 32'sh7FFFFFFF;
    xs[2] = 32'sh7FFFFFFF;
    xs[3] = 32'sh80000000;
    xs[4] = 32'sh80000000;
    mXh = '0;
    mYh = '0;
    for (int i = 0; i < 5; i++) begin
      modelStep(xs[i], ym);
      addVec(i == 0, xs[i], ym, "wrap_model");
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].resetFirst) doReset();
      applyStimulus(vecs[i].x);
      waitWrite(vecs[i].y, $sformatf("%s[%0d]", vecs[i].name, i));
    end

    // Latency: one CALC cycle, then the write strobe.
    doReset();
    applyStimulus(1024);
    #1;
    checkOutput("lat_calc_wr", W'(y_wr_en), 0);
    @(negedge clock);
    #1;
    checkOutput("lat_write_wr", W'(y_wr_en), 1);
    checkOutput("lat_write_y", y_out, 178);
    @(negedge clock);

    // Backpressure with the next sample already offered upstream.
    doReset();
    y_out_full = 1'b1;
    applyStimulus(1024);
    x_in    = 1024;
    x_empty = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      #1;
      checkOutput($sformatf("bp_wr_en[%0d]", i), W'(y_wr_en), 0);
      checkOutput($sformatf("bp_rd_en[%0d]", i), W'(x_rd_en), 0);
      checkOutput($sformatf("bp_y_out[%0d]", i), y_out, 178);
      @(negedge clock);
    end
    y_out_full = 1'b0;
    #1;
    checkOutput("bp_release_wr", W'(y_wr_en), 1);
    checkOutput("bp_release_y", y_out, 178);
    @(negedge clock);
    #1;
    checkOutput("bp_no_dup_wr", W'(y_wr_en), 0);
    checkOutput("bp_next_rd", W'(x_rd_en), 1);
    @(negedge clock);
    x_empty = 1'b1;
    waitWrite(241, "bp_resume_1");
    applyStimulus(1024);
    waitWrite(200, "bp_resume_2");

    // Starvation.
    doReset();
    x_empty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checkOutput($sformatf("starve_rd[%0d]", i), W'(x_rd_en), 0);
      checkOutput($sformatf("starve_wr[%0d]", i), W'(y_wr_en), 0);
      checkOutput($sformatf("starve_state[%0d]", i), W'(dut.state_q), 0);
      @(negedge clock);
    end
    applyStimulus(1024);
    waitWrite(178, "starve_after");

    // Reset pulse while the second step sample sits in CALC.
    doReset();
    applyStimulus(1024);
    waitWrite(178, "rst_mid_first");
    applyStimulus(1024);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_y_out", y_out, 0);
    checkOutput("rst_mid_rd", W'(x_rd_en), 0);
    checkOutput("rst_mid_wr", W'(y_wr_en), 0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1024);
    waitWrite(178, "rst_mid_restart");
    applyStimulus(1024);
    waitWrite(241, "rst_mid_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
